sub16_serial: RTL and testbench

SUB16_SERIAL -- requirements
Module: sub16_serial

---
 rtl/sub16_serial.sv | 101 ++++++++++
 tb/tb_sub16_serial.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sub16_serial.sv
// Nibble-serial 16-bit subtractor: computes a - b - bin one nibble per cycle
// and reports borrow-out, signed overflow and zero once all four nibbles are done.
module sub16_serial (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        bin,
   output logic [15:0] diff,
   output logic        bout,
   output logic        ovf,
   output logic        zero,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_nx;
   logic [1:0]  idx;
   logic [15:0] a_r, b_r;
   logic        brw;
   logic [3:0]  lsb;
   logic [4:0]  nib_sum;
   logic [15:0] diff_nx;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // NOTE: every output of this block gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: if (start) state_nx = RUN;
         RUN: begin
            busy = 1'b1;
            if (idx == 2'd3) state_nx = DONE;
         end
         DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Subtraction as addition of the complement; the carry-out is the inverted borrow.
   always_comb begin
      lsb     = {idx, 2'b00};
      nib_sum = {1'b0, a_r[lsb +: 4]} + {1'b0, ~b_r[lsb +: 4]} + {4'b0000, ~brw};
      diff_nx = diff;
      diff_nx[lsb +: 4] = nib_sum[3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx  <= 2'd0;
         a_r  <= 16'h0000;
         b_r  <= 16'h0000;
         brw  <= 1'b0;
         diff <= 16'h0000;
         bout <= 1'b0;
         ovf  <= 1'b0;
         zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_r  <= a;
               b_r  <= b;
               brw  <= bin;
               idx  <= 2'd0;
               bout <= 1'b0;
               ovf  <= 1'b0;
               zero <= 1'b0;
            end
            RUN: begin
               diff <= diff_nx;
               brw  <= ~nib_sum[4];
               idx  <= idx + 2'd1;
               // Flags are derived from the fully assembled result, including the last nibble.
               if (idx == 2'd3) begin
                  bout <= ~nib_sum[4];
                  ovf  <= (a_r[15] != b_r[15]) && (diff_nx[15] != a_r[15]);
                  zero <= (diff_nx == 16'h0000);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sub16_serial.sv
// Self-checking bench for sub16_serial: arithmetic reference model with a
// per-cycle compare process, directed literal vectors and randomized traffic.
module tb_sub16_serial;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = 16'h0000;
   logic [15:0] b = 16'h0000;
   logic        bin = 1'b0;
   logic [15:0] diff;
   logic        bout, ovf, zero, busy, done;

   int n_cmp = 0;
   int n_err = 0;
   bit started = 1'b0;

   sub16_serial dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .bin  (bin),
      .diff (diff),
      .bout (bout),
      .ovf  (ovf),
      .zero (zero),
      .busy (busy),
      .done (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: cycles elapsed since an accepted start (0 = idle, 5 = result cycle).
   int          m_cnt = 0;
   logic [15:0] exp_diff = 16'h0000;
   logic        exp_bout = 1'b0, exp_ovf = 1'b0, exp_zero = 1'b0;
   logic [15:0] pend_diff;
   logic        pend_bout, pend_ovf, pend_zero;

   always @(posedge clk) begin
      if (rst) begin
         m_cnt    = 0;
         exp_diff = 16'h0000;
         exp_bout = 1'b0;
         exp_ovf  = 1'b0;
         exp_zero = 1'b0;
      end else if (m_cnt == 0) begin
         if (start) begin
            m_cnt     = 1;
            pend_diff = a - b - 16'(bin);
            pend_bout = (int'(a) < int'(b) + int'(bin));
            pend_ovf  = (a[15] != b[15]) && (pend_diff[15] != a[15]);
            pend_zero = (pend_diff == 16'h0000);
            exp_bout  = 1'b0;
            exp_ovf   = 1'b0;
            exp_zero  = 1'b0;
         end
      end else if (m_cnt == 5) begin
         m_cnt = 0;
      end else begin
         m_cnt++;
         if (m_cnt == 5) begin
            exp_diff = pend_diff;
            exp_bout = pend_bout;
            exp_ovf  = pend_ovf;
            exp_zero = pend_zero;
         end
      end
   end

   // Compare process: diff is only meaningful outside the run window.
   always @(negedge clk) begin
      if (started) begin
         check("busy", 32'(busy), 32'(m_cnt != 0));
         check("done", 32'(done), 32'(m_cnt == 5));
         if (m_cnt == 0 || m_cnt == 5) check("diff", 32'(diff), 32'(exp_diff));
         check("bout", 32'(bout), 32'(exp_bout));
         check("ovf",  32'(ovf),  32'(exp_ovf));
         check("zero", 32'(zero), 32'(exp_zero));
      end
   end

   task automatic run_lit(input string nm, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tbin, input logic [15:0] ed, input logic ebo,
                          input logic eov, input logic ez);
      int lat;
      @(negedge clk);
      start = 1'b1; a = ta; b = tb_v; bin = tbin;
      @(negedge clk);
      start = 1'b0; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      lat = 1;
      while (!done && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      check({nm, "_latency"}, 32'(lat), 32'd5);
      check({nm, "_diff"}, 32'(diff), 32'(ed));
      check({nm, "_bout"}, 32'(bout), 32'(ebo));
      check({nm, "_ovf"},  32'(ovf),  32'(eov));
      check({nm, "_zero"}, 32'(zero), 32'(ez));
      @(negedge clk);
   endtask

   initial begin
      int n_done;
      logic [15:0] seen_diff;

      repeat (2) @(negedge clk);
      check("rst_diff", 32'(diff), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_flags", 32'({bout, ovf, zero}), 32'h0);
      rst = 1'b0;
      started = 1'b1;

      run_lit("v035",  16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
      run_lit("v036a", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      run_lit("v036b", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      run_lit("v037a", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      run_lit("v037b", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
      run_lit("v038",  16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      run_lit("wrap",  16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

      // A second start while busy must be dropped, not queued.
      @(negedge clk); start = 1'b1; a = 16'hA000; b = 16'h0001; bin = 1'b0;
      @(negedge clk); start = 1'b0; a = 16'h0000; b = 16'h0000;
      @(negedge clk); start = 1'b1; a = 16'h0000; b = 16'h0000; bin = 1'b1;
      @(negedge clk); start = 1'b0;
      n_done = 0;
      seen_diff = 16'h0000;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            n_done++;
            seen_diff = diff;
         end
         @(negedge clk);
      end
      check("ign_done_cnt", 32'(n_done), 32'd1);
      check("ign_diff", 32'(seen_diff), 32'h9FFF);

      // Reset while nibble 2 is pending aborts the operation.
      @(negedge clk); start = 1'b1; a = 16'h1234; b = 16'h0234; bin = 1'b0;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_diff", 32'(diff), 32'h0);
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) n_done++;
         @(negedge clk);
      end
      check("abort_no_done", 32'(n_done), 32'd0);
      run_lit("post_rst", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

      // Back-to-back random operations at the minimum issue interval, with
      // junk inputs and stray start requests while busy.
      for (int n = 0; n < 10000; n++) begin
         @(negedge clk);
         start = 1'b1; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
         if (n % 8 == 0) b = 16'hFFFF;
         if (n % 8 == 1) b = a;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'($urandom); a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
         end
      end
      @(negedge clk); start = 1'b0;
      repeat (8) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
